// File: rtl/shared_reg_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin shared-register arbiter.
package shared_reg_rr_arbiter_pkg;

    // Arbiter is either waiting for a request or serving a lease
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    // Widest requester vector supported by the helpers below
    localparam int MAX_N = 16;

    // Bits needed to hold an index in 0..n-1, never less than one
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // One-hot vector with bit idx set; callers truncate to their width
    function automatic logic [MAX_N-1:0] onehot(input int idx);
        return MAX_N'(1) << idx;
    endfunction

endpackage

// File: rtl/shared_reg_rr_arbiter_if.sv
// Requester-side bus of the arbiter: requests/data in, grant/register out.
interface shared_reg_rr_arbiter_if #(
    parameter int N = 4,
    parameter int W = 8
);
    import shared_reg_rr_arbiter_pkg::*;

    localparam int IW = idx_w(N);

    logic [N-1:0]   req;
    logic [N*W-1:0] din;
    logic [N-1:0]   gnt;
    logic [N-1:0]   ack;
    logic [W-1:0]   q;
    logic           q_valid;
    logic [IW-1:0]  owner;
    logic           busy;

    // Requester side drives requests and data
    modport master (
        output req, din,
        input  gnt, ack, q, q_valid, owner, busy
    );

    // Arbiter side
    modport slave (
        input  req, din,
        output gnt, ack, q, q_valid, owner, busy
    );

endinterface

// File: rtl/shared_reg_rr_arbiter_rr_pick.sv
// Combinational round-robin pick: first requester at or after ptr wins.
module shared_reg_rr_arbiter_rr_pick
    import shared_reg_rr_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] winner,
    output logic          any_req
);

    logic [N-1:0] rot;

    // Rotate so that the requester at ptr lands on bit 0
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_rot
            logic [IW-1:0] src_idx;
            assign src_idx = IW'((int'(ptr) + gi) % N);
            assign rot[gi] = req[src_idx];
        end
    endgenerate

    // Priority-encode the rotated vector and map the offset back to an index
    always_comb begin
        int  off;
        logic found;
        off   = 0;
        found = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!found && rot[j]) begin
                found = 1'b1;
                off   = j;
            end
        end
        winner  = IW'((int'(ptr) + off) % N);
        any_req = |req;
    end

endmodule

// File: rtl/shared_reg_rr_arbiter.sv
// Round-robin arbiter granting timed leases on one shared W-bit register.
module shared_reg_rr_arbiter
    import shared_reg_rr_arbiter_pkg::*;
#(
    parameter int N           = 4,
    parameter int W           = 8,
    parameter int HOLD_CYCLES = 4
) (
    input logic                    clk,
    input logic                    rst,
    shared_reg_rr_arbiter_if.slave bus
);

    localparam int IW = idx_w(N);
    localparam int CW = idx_w(HOLD_CYCLES);

    state_e        state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [N-1:0]  ack_q, ack_d;
    logic [W-1:0]  q_q, q_d;
    logic          q_valid_q, q_valid_d;
    logic [IW-1:0] owner_q, owner_d;
    logic          busy_q, busy_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [IW-1:0] win_idx;
    logic          any_req;
    logic [W-1:0]  din_arr [N];

    // Split the packed data bus into one word per requester
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_din
            assign din_arr[gi] = bus.din[gi*W +: W];
        end
    endgenerate

    shared_reg_rr_arbiter_rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req     (bus.req),
        .ptr     (ptr_q),
        .winner  (win_idx),
        .any_req (any_req)
    );

    // Next-state logic: load on a win, follow owner's data, release on drop or lease expiry
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        ack_d     = '0;
        q_d       = q_q;
        q_valid_d = q_valid_q;
        owner_d   = owner_q;
        busy_d    = busy_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d   = HOLD;
                    gnt_d     = N'(onehot(int'(win_idx)));
                    ack_d     = N'(onehot(int'(win_idx)));
                    owner_d   = win_idx;
                    q_d       = din_arr[win_idx];
                    q_valid_d = 1'b1;
                    busy_d    = 1'b1;
                    cnt_d     = CW'(HOLD_CYCLES - 1);
                end
            end
            HOLD: begin
                if (!bus.req[owner_q] || cnt_q == '0) begin
                    // q and owner keep the last lease's values
                    state_d = IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    ptr_d   = (int'(owner_q) == N - 1) ? '0 : owner_q + 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    q_d   = din_arr[owner_q];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; active-low reset wins over everything
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            ack_q     <= '0;
            q_q       <= '0;
            q_valid_q <= 1'b0;
            owner_q   <= '0;
            busy_q    <= 1'b0;
            ptr_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            ack_q     <= ack_d;
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
            owner_q   <= owner_d;
            busy_q    <= busy_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.ack     = ack_q;
    assign bus.q       = q_q;
    assign bus.q_valid = q_valid_q;
    assign bus.owner   = owner_q;
    assign bus.busy    = busy_q;

endmodule

// File: tb/tb_shared_reg_rr_arbiter.sv
// Directed plus randomized bench for shared_reg_rr_arbiter with a lease-level reference model.
module tb_shared_reg_rr_arbiter;
    import shared_reg_rr_arbiter_pkg::*;

    localparam int N    = 4;
    localparam int W    = 8;
    localparam int HOLD = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    shared_reg_rr_arbiter_if #(.N(N), .W(W)) bus ();

    shared_reg_rr_arbiter #(
        .N           (N),
        .W           (W),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [W-1:0] din_v [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_pack
            assign bus.din[gi*W +: W] = din_v[gi];
        end
    endgenerate

    // Reference model: a lease is "who owns it" and "how many edges it has loaded q"
    bit           m_leased;
    int           m_owner;
    int           m_next_first;
    int           m_loads;
    bit           m_valid;
    bit           m_new_lease;
    logic [W-1:0] m_q;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Apply the rules for one clock edge to the model, using the inputs the DUT sampled
    task automatic model_edge();
        m_new_lease = 1'b0;
        if (!rst) begin
            m_leased = 1'b0; m_owner = 0; m_next_first = 0;
            m_loads = 0; m_valid = 1'b0; m_q = '0;
        end else if (!m_leased) begin
            for (int k = 0; k < N; k++) begin
                int cand;
                cand = (m_next_first + k) % N;
                if (!m_leased && bus.req[cand]) begin
                    m_leased = 1'b1; m_owner = cand; m_loads = 1;
                    m_q = din_v[cand]; m_valid = 1'b1; m_new_lease = 1'b1;
                end
            end
        end else if (!bus.req[m_owner] || m_loads == HOLD) begin
            m_leased = 1'b0;
            m_next_first = (m_owner + 1) % N;
        end else begin
            m_loads++;
            m_q = din_v[m_owner];
        end
    endtask

    task automatic check_all();
        logic [N-1:0] exp_gnt;
        exp_gnt = m_leased ? N'(1 << m_owner) : '0;
        chk("gnt", 32'(bus.gnt), 32'(exp_gnt));
        chk("ack", 32'(bus.ack), m_new_lease ? 32'(exp_gnt) : 32'd0);
        chk("q", 32'(bus.q), 32'(m_q));
        chk("q_valid", 32'(bus.q_valid), 32'(m_valid));
        chk("owner", 32'(bus.owner), 32'(m_owner));
        chk("busy", 32'(bus.busy), 32'(m_leased));
        if (bus.ack != '0)
            $display("cycle %0d: grant owner=%0d q=0x%02h", cyc, bus.owner, bus.q);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        check_all();
    endtask

    int ack_owner[$];
    int ack_cyc[$];

    initial begin
        bus.req = '0;
        for (int i = 0; i < N; i++) din_v[i] = '0;
        #2;

        // Reset held two edges while everyone requests
        rst = 1'b0; bus.req = 4'b1111;
        step(); step();
        chk("rst_q", 32'(bus.q), 32'h00);
        chk("rst_gnt", 32'(bus.gnt), 32'h0);
        rst = 1'b1; bus.req = '0;
        step();

        // Single request runs a full lease then releases on expiry
        bus.req = 4'b0001; din_v[0] = 8'hA5;
        step();
        chk("single_ack", 32'(bus.ack), 32'b0001);
        chk("single_q", 32'(bus.q), 32'hA5);
        repeat (3) step();
        chk("single_gnt4", 32'(bus.gnt), 32'b0001);
        step();
        chk("single_rel", 32'(bus.gnt), 32'b0000);
        chk("single_hold_q", 32'(bus.q), 32'hA5);
        bus.req = '0;
        step();

        // Saturated load from ptr=0: owners rotate with 5-cycle spacing
        rst = 1'b0; step(); rst = 1'b1;
        bus.req = 4'b1111;
        for (int c = 0; c < 25; c++) begin
            step();
            if (bus.ack != '0) begin
                ack_owner.push_back(int'(bus.owner));
                ack_cyc.push_back(c);
            end
        end
        chk("fair_count", 32'(ack_owner.size()), 32'd5);
        for (int i = 0; i < ack_owner.size(); i++) begin
            chk("fair_owner", 32'(ack_owner[i]), 32'(i % N));
            if (i > 0) chk("fair_spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd5);
        end
        bus.req = '0;
        repeat (6) step();

        // Early release by owner 2, then 3 and 1 are served in that order
        rst = 1'b0; step(); rst = 1'b1;
        bus.req = 4'b0100;
        step();
        chk("early_owner", 32'(bus.owner), 32'd2);
        bus.req = 4'b1110;
        step();
        bus.req = 4'b1010;
        step();
        chk("early_rel", 32'(bus.gnt), 32'b0000);
        step();
        chk("early_next3", 32'(bus.gnt), 32'b1000);
        repeat (4) step();
        step();
        chk("early_then1", 32'(bus.gnt), 32'b0010);
        bus.req = '0;
        repeat (5) step();

        // Register follows owner's data mid-lease and freezes after release
        rst = 1'b0; step(); rst = 1'b1;
        din_v[1] = 8'h10; bus.req = 4'b0010;
        step();
        chk("follow_load", 32'(bus.q), 32'h10);
        din_v[1] = 8'h20;
        step();
        chk("follow_q", 32'(bus.q), 32'h20);
        bus.req = '0;
        step();
        din_v[1] = 8'h30;
        step();
        chk("follow_frozen", 32'(bus.q), 32'h20);

        // Reset in the middle of a lease, then a fresh arbitration from ptr=0
        bus.req = 4'b0001;
        step(); step();
        rst = 1'b0;
        step();
        chk("midrst_gnt", 32'(bus.gnt), 32'h0);
        chk("midrst_valid", 32'(bus.q_valid), 32'h0);
        rst = 1'b1; bus.req = 4'b1010;
        step();
        chk("midrst_regrant", 32'(bus.gnt), 32'b0010);

        // Randomized traffic: sticky requests, changing data, rare resets
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(3) == 0) bus.req[i] = ~bus.req[i];
                din_v[i] = W'($urandom);
            end
            rst = ($urandom_range(99) == 0) ? 1'b0 : 1'b1;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/shared_reg_rr_arbiter.md
Name: shared_reg_rr_arbiter

Overview:
- Round-robin arbiter that shares one W-bit storage register (a bank of synchronous D flops with active-low reset) among N requesters.
- The winning requester gets a grant lease of up to HOLD_CYCLES cycles. During the lease the register follows that requester's data input.
- Sits between requester blocks and the shared register output consumed downstream.

Parameters:
- N, 4, number of requesters (2..16)
- W, 8, data/register width
- HOLD_CYCLES, 4, maximum lease length in cycles (>=1)

Ports:
- clk  input  1  system clock, all state updates on posedge
- rst  input  1  reset, synchronous, active-low; sampled only at posedge clk
- req  input  N  per-requester request level, held while ownership is wanted
- din  input  N*W  packed data; requester i occupies bits [i*W +: W]
- gnt  output  N  one-hot grant, high for the whole lease
- ack  output  N  one-cycle pulse to the winner in the first grant cycle
- q  output  W  shared register value
- q_valid  output  1  register has been written at least once since reset
- owner  output  max(1,$clog2(N))  index of the current or most recent owner
- busy  output  1  high while in HOLD

Behaviour:
- Reset (rst==0 at posedge) forces: state=IDLE, q=0, q_valid=0, gnt=0, ack=0, owner=0, busy=0, rr pointer ptr=0, lease counter cnt=0. Reset has priority over everything, including in the middle of a lease.
- States: IDLE and HOLD.
- IDLE, req==0: no change; gnt=0, ack=0.
- IDLE, req!=0, winner w chosen at edge k:
  - w = first i with req[i]==1 scanning ptr, ptr+1, … mod N.
  - After edge k: state=HOLD, gnt=onehot(w), ack=onehot(w) for exactly one cycle, owner=w, q=din[w], q_valid=1, busy=1, cnt=HOLD_CYCLES-1.
  - Latency from req to gnt/q is 1 edge.
- HOLD, at each edge, in this order:
  - If req[owner]==0 or cnt==0: release. gnt=0, busy=0, state=IDLE, ptr=(owner+1) mod N. q and owner are held.
  - Otherwise: cnt=cnt-1 and q=din[owner].
  - ack=0 in all HOLD cycles after the first.
- Lease length:
  - gnt stays high for exactly HOLD_CYCLES cycles when req is held.
  - q is updated on HOLD_CYCLES consecutive edges: the load edge plus HOLD_CYCLES-1 follow edges.
  - HOLD_CYCLES=1 gives a single-cycle grant.
- Early release: if the owner drops req, gnt deasserts on the next edge. The last sampled din is not written on that edge.
- Re-arbitration:
  - Always at least one IDLE cycle between leases, so a saturated 4-requester load with HOLD=4 has a grant period of 5 cycles.
  - Requests from non-owners during HOLD are ignored until IDLE.
- The ptr update makes the just-served requester lowest priority next round. Requesters have no starvation while they hold req.
- din of non-owners never affects q. Outside HOLD, q is stable.
- req bits outside 0..N-1 do not exist. X on req of non-owners is don't-care during HOLD.

Decomposition:
- Shared package holds:
  - state enum (IDLE, HOLD)
  - idx-width helper function
  - onehot-from-index function
- One combinational sub-module, rr_pick, is natural.
  - Inputs: req[N], ptr.
  - Outputs: winner index, any_req.
  - Implementation: rotate, priority-encode, un-rotate.
- The top module holds the FSM, cnt, ptr and the q register.

Test Plan (N=4, W=8, HOLD_CYCLES=4):
- Reset: rst=0 for 2 edges with req=1111 -> q=0x00, q_valid=0, gnt=0000, ack=0000, busy=0, owner=0.
- Single request: req=0001, din0=0xA5 -> after 1 edge gnt=0001, ack=0001 for 1 cycle, q=0xA5, q_valid=1. gnt high 4 cycles, then gnt=0000 and busy=0; q stays 0xA5.
- Fairness: req=1111 held -> owners in order 0,1,2,3,0. Each lease is 4 gnt cycles plus 1 IDLE cycle; ack pulses at 5-cycle spacing.
- Early release: owner 2 drops req after 2 gnt cycles while req1 and req3 are high -> gnt=0000 on next edge, ptr=3. Next grant goes to 3, then 1.
- Follow/hold: owner 1 with din1=0x10 changing to 0x20 mid-lease -> q=0x20 one edge later. A din1 change to 0x30 after release leaves q=0x20.
- Reset mid-lease: rst=0 on the second HOLD cycle -> next edge gives all outputs 0 and ptr=0. Then with rst=1 and req=1010 -> grant 0010 (requester 1).
